// File: rtl/dcache_controller_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : dcache_controller_if                                       |
// | Brief    : CPU-side and memory-side bus bundle for the L1 data cache. |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
interface dcache_controller_if;
   logic          cpu_req_i;
   logic          cpu_write_i;
   logic [31:0]   cpu_addr_i;
   logic [31:0]   cpu_data_i;
   logic [31:0]   cpu_data_o;
   logic          cpu_stall_o;
   logic          mem_enable_o;
   logic          mem_write_o;
   logic [31:0]   mem_addr_o;
   logic [255:0]  mem_data_o;
   logic          mem_ack_i;
   logic [255:0]  mem_data_i;

   modport master (
      input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_ack_i, mem_data_i,
      output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
   );

   modport slave (
      output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_ack_i, mem_data_i,
      input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
   );
endinterface
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : dcache_controller                                          |
// | Brief    : Direct-mapped write-back write-allocate L1 data cache.     |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module dcache_controller #(
   parameter int SETS     = 16,
   parameter int INDEX_W  = 4,
   parameter int OFFSET_W = 5
) (
   input  logic                clk_i,
   input  logic                rst_i,
   dcache_controller_if.master bus
);

   localparam int c_TAG_W  = 32 - INDEX_W - OFFSET_W;
   localparam int c_WORD_W = OFFSET_W - 2;
   localparam logic [OFFSET_W-1:0] c_OFF_ZERO = '0;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WRITEBACK = 2'd1,
      S_ALLOCATE  = 2'd2,
      S_FILL      = 2'd3
   } state_t;

   state_t                r_state;
   logic [255:0]          r_data_arr [SETS];
   logic [c_TAG_W-1:0]    r_tag_arr  [SETS];
   logic [SETS-1:0]       r_valid;
   logic [SETS-1:0]       r_dirty;
   logic                  r_mem_enable;
   logic                  r_mem_write;
   logic [31:0]           r_mem_addr;
   logic [255:0]          r_mem_data;
   logic [INDEX_W-1:0]    r_fill_idx;
   logic [c_TAG_W-1:0]    r_fill_tag;

   logic [c_TAG_W-1:0]    w_tag;
   logic [INDEX_W-1:0]    w_idx;
   logic [c_WORD_W-1:0]   w_word;
   logic [255:0]          w_line;
   logic                  w_hit;
   logic                  w_miss;
   logic                  w_store_hit;
   logic                  w_unused;

   assign w_tag       = bus.cpu_addr_i[31 -: c_TAG_W];
   assign w_idx       = bus.cpu_addr_i[OFFSET_W +: INDEX_W];
   assign w_word      = bus.cpu_addr_i[2 +: c_WORD_W];
   assign w_line      = r_data_arr[w_idx];
   assign w_unused    = ^bus.cpu_addr_i[1:0];

   assign w_hit       = bus.cpu_req_i & r_valid[w_idx] & (r_tag_arr[w_idx] == w_tag);
   assign w_miss      = bus.cpu_req_i & ~w_hit & (r_state == S_IDLE);
   assign w_store_hit = w_hit & bus.cpu_write_i & (r_state == S_IDLE);

   assign bus.cpu_stall_o  = (bus.cpu_req_i & ~w_hit) | (r_state != S_IDLE);
   assign bus.cpu_data_o   = (w_hit & ~bus.cpu_write_i) ? w_line[{w_word, 5'b0} +: 32] : 32'd0;
   assign bus.mem_enable_o = r_mem_enable;
   assign bus.mem_write_o  = r_mem_write;
   assign bus.mem_addr_o   = r_mem_addr;
   assign bus.mem_data_o   = r_mem_data;

   // Line storage carries no reset; validity is tracked separately.
   always_ff @(posedge clk_i) begin
      if (r_state == S_FILL) begin
         r_data_arr[r_fill_idx] <= bus.mem_data_i;
         r_tag_arr[r_fill_idx]  <= r_fill_tag;
      end else if (w_store_hit) begin
         r_data_arr[w_idx][{w_word, 5'b0} +: 32] <= bus.cpu_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_valid      <= '0;
         r_dirty      <= '0;
         r_mem_enable <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_data   <= '0;
         r_fill_idx   <= '0;
         r_fill_tag   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_store_hit) begin
                  r_dirty[w_idx] <= 1'b1;
               end
               // Miss target is latched so a dropped request still completes its fill.
               if (w_miss) begin
                  r_fill_idx   <= w_idx;
                  r_fill_tag   <= w_tag;
                  r_mem_enable <= 1'b1;
                  if (r_valid[w_idx] && r_dirty[w_idx]) begin
                     r_state     <= S_WRITEBACK;
                     r_mem_write <= 1'b1;
                     r_mem_addr  <= {r_tag_arr[w_idx], w_idx, c_OFF_ZERO};
                     r_mem_data  <= w_line;
                  end else begin
                     r_state     <= S_ALLOCATE;
                     r_mem_write <= 1'b0;
                     r_mem_addr  <= {w_tag, w_idx, c_OFF_ZERO};
                  end
               end
            end
            S_WRITEBACK: begin
               if (bus.mem_ack_i) begin
                  r_state     <= S_ALLOCATE;
                  r_mem_write <= 1'b0;
                  r_mem_addr  <= {r_fill_tag, r_fill_idx, c_OFF_ZERO};
               end
            end
            S_ALLOCATE: begin
               if (bus.mem_ack_i) begin
                  r_state      <= S_FILL;
                  r_mem_enable <= 1'b0;
               end
            end
            S_FILL: begin
               r_valid[r_fill_idx] <= 1'b1;
               r_dirty[r_fill_idx] <= 1'b0;
               r_state             <= S_IDLE;
            end
            default: begin
               r_state      <= S_IDLE;
               r_mem_enable <= 1'b0;
               r_mem_write  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
